// File: rtl/cpu_pkg.sv
// Shared opcode, ALU select and FSM state encodings for the 8-bit single-cycle CPU control path.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Opcodes are dense from 0x00, so legality is a single compare.
    function automatic logic is_legal(input logic [7:0] opcode);
        return opcode <= OP_BEQ;
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with sequential (+4) and relative word-offset target adders.
module pc_unit #(
    parameter int          PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            take_branch,
    input  logic            hold,
    input  logic [7:0]      offset,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] offset_ext;
    logic [PC_W-1:0] target;

    assign pc_plus4   = pc_reg + PC_W'(4);
    assign offset_ext = {{(PC_W-8){offset[7]}}, offset};
    // Offset counts words relative to the following instruction; wraps modulo 2^PC_W.
    assign target     = pc_plus4 + (offset_ext << 2);

    always_comb begin
        pc_next = pc_plus4;
        if (hold)
            pc_next = pc_reg;
        else if (take_branch)
            pc_next = target;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc_reg <= RESET_PC;
        else
            pc_reg <= pc_next;
    end

    assign pc = pc_reg;

endmodule

// File: rtl/cpu_control.sv
// Instruction decoder plus run/stall/halt sequencer; drives the ALU/register-file controls and owns the PC.
module cpu_control
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTRUCTION,
    input  logic            ZERO,
    input  logic            BUSYWAIT,
    output logic [PC_W-1:0] PC,
    output logic [2:0]      ALUOP,
    output logic            WRITEENABLE,
    output logic            IMMSEL,
    output logic            NEGSEL,
    output logic [2:0]      WRITEREG,
    output logic [2:0]      READREG1,
    output logic [2:0]      READREG2,
    output logic            HALTED
);

    state_t      state_reg;
    logic        halted_reg;

    logic [7:0]  opcode;
    logic        legal;
    logic        dec_we;
    logic        is_jump;
    logic        is_beq;
    logic        take_branch;
    logic        pc_hold;
    logic        unused_bits;

    assign opcode   = INSTRUCTION[31:24];
    assign legal    = is_legal(opcode);
    assign WRITEREG = INSTRUCTION[18:16];
    assign READREG1 = INSTRUCTION[10:8];
    assign READREG2 = INSTRUCTION[2:0];

    // Register-address high bits and the immediate feed the datapath directly, not this block.
    assign unused_bits = ^{INSTRUCTION[15:11], INSTRUCTION[7:3]};

    always_comb begin
        ALUOP   = ALU_FWD;
        IMMSEL  = 1'b0;
        NEGSEL  = 1'b0;
        dec_we  = 1'b0;
        is_jump = 1'b0;
        is_beq  = 1'b0;
        case (opcode)
            OP_LOADI: begin IMMSEL = 1'b1; dec_we = 1'b1; end
            OP_MOV:   dec_we = 1'b1;
            OP_ADD:   begin ALUOP = ALU_ADD; dec_we = 1'b1; end
            OP_SUB:   begin ALUOP = ALU_ADD; NEGSEL = 1'b1; dec_we = 1'b1; end
            OP_AND:   begin ALUOP = ALU_AND; dec_we = 1'b1; end
            OP_OR:    begin ALUOP = ALU_OR;  dec_we = 1'b1; end
            OP_J:     is_jump = 1'b1;
            OP_BEQ:   begin ALUOP = ALU_ADD; NEGSEL = 1'b1; is_beq = 1'b1; end
            default:  ;
        endcase
    end

    // Writes only retire from RUN, and never while reset is held.
    assign WRITEENABLE = dec_we && (state_reg == ST_RUN) && RESET;

    assign take_branch = is_jump || (is_beq && ZERO);
    assign pc_hold     = (state_reg != ST_RUN) || BUSYWAIT || !legal;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (BUSYWAIT) begin
                        state_reg <= ST_STALL;
                    end else if (!legal) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (!BUSYWAIT)
                        state_reg <= ST_RUN;
                end
                ST_HALT: begin
                    halted_reg <= 1'b1;
                end
                default: begin
                    state_reg  <= ST_HALT;
                    halted_reg <= 1'b1;
                end
            endcase
        end
    end

    assign HALTED = halted_reg;

    pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk         (CLK),
        .rst_n       (RESET),
        .take_branch (take_branch),
        .hold        (pc_hold),
        .offset      (INSTRUCTION[23:16]),
        .pc          (PC)
    );

endmodule
